// File: rtl/frame_timer_pkg.sv
// Shared types and constants for the frame-synchronous pattern timer.
package frame_timer_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/vsync_edge_sync.sv
// Synchronises the asynchronous panel vsync and emits a registered one-cycle pulse
// per rising edge, suppressed until the chain has settled after reset.
module vsync_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic iclk,
    input  logic irst,
    input  logic ivsync,
    output logic orise
);

    localparam int                PRIME_W   = $clog2(SYNC_STAGES + 2);
    localparam logic [PRIME_W-1:0] PRIME_MAX = PRIME_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [PRIME_W-1:0]     prime_q;
    logic                   primed;

    // A level already high at reset release must not look like an edge.
    assign primed = (prime_q == PRIME_MAX);

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the chain shifts one stage per clock.
    always_ff @(posedge iclk) begin
        if (irst) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            prime_q <= '0;
            orise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ivsync};
            prev_q <= sync_q[SYNC_STAGES-1];
            if (!primed)
                prime_q <= prime_q + 1'b1;
            orise <= primed & sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/frame_timer.sv
// Counts qualified vsync edges, ticks every iframes_per_tick frames and advances a
// tick counter modulo iterminal in wrap or one-shot mode.
module frame_timer
    import frame_timer_pkg::*;
#(
    parameter int FPT_W       = 10,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             iclk,
    input  logic             irst,
    input  logic             ivsync,
    input  logic             ien,
    input  logic             iclr,
    input  logic             imode,
    input  logic [FPT_W-1:0] iframes_per_tick,
    input  logic [CNT_W-1:0] iterminal,
    output logic             ovs_rise,
    output logic             otick,
    output logic             owrap,
    output logic             odone,
    output logic [CNT_W-1:0] oCount
);

    logic             rise;
    state_t           state_q, state_d;
    logic [FPT_W-1:0] fcnt_q, fcnt_d, f_last;
    logic [CNT_W-1:0] cnt_d, term_last;
    logic             count_en, tick_d, wrap_d, done_d, finish_d;

    vsync_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .iclk  (iclk),
        .irst  (irst),
        .ivsync(ivsync),
        .orise (rise)
    );

    // F = 0 behaves as F = 1; M = 0 becomes all-ones, i.e. modulus 2^CNT_W.
    assign f_last    = (iframes_per_tick == '0) ? '0 : iframes_per_tick - 1'b1;
    assign term_last = iterminal - 1'b1;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        cnt_d    = oCount;
        tick_d   = 1'b0;
        wrap_d   = 1'b0;
        done_d   = odone;
        finish_d = 1'b0;
        count_en = rise && ien && (state_q == RUN);

        if (count_en) begin
            if (fcnt_q >= f_last) begin
                fcnt_d = '0;
                tick_d = 1'b1;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end

        if (tick_d) begin
            if (imode == MODE_WRAP) begin
                if (oCount >= term_last) begin
                    cnt_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = oCount + 1'b1;
                end
            end else if (oCount == term_last) begin
                finish_d = 1'b1;
                done_d   = 1'b1;
            end else begin
                cnt_d = oCount + 1'b1;
            end
        end

        case (state_q)
            RUN:     if (!ien) state_d = HOLD;
                     else if (finish_d) state_d = DONE;
            HOLD:    if (ien) state_d = RUN;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q  <= RUN;
            fcnt_q   <= '0;
            oCount   <= '0;
            otick    <= 1'b0;
            owrap    <= 1'b0;
            odone    <= 1'b0;
            ovs_rise <= 1'b0;
        end else begin
            ovs_rise <= rise;
            if (iclr) begin
                // A rise in the clear cycle still shows on ovs_rise but is not counted.
                state_q <= ien ? RUN : HOLD;
                fcnt_q  <= '0;
                oCount  <= '0;
                otick   <= 1'b0;
                owrap   <= 1'b0;
                odone   <= 1'b0;
            end else begin
                state_q <= state_d;
                fcnt_q  <= fcnt_d;
                oCount  <= cnt_d;
                otick   <= tick_d;
                owrap   <= wrap_d;
                odone   <= done_d;
            end
        end
    end

endmodule

// File: tb/tb_frame_timer.sv
// Self-checking bench for frame_timer: directed tables, corner sequences and a
// randomized run against a frame-level reference model.
module tb_frame_timer;
    import frame_timer_pkg::*;

    localparam int FPT_W = 10;
    localparam int CNT_W = 8;
    localparam int S     = 2;

    logic             iclk = 1'b0;
    logic             irst, ivsync, ien, iclr, imode;
    logic [FPT_W-1:0] iframes_per_tick;
    logic [CNT_W-1:0] iterminal;
    logic             ovs_rise, otick, owrap, odone;
    logic [CNT_W-1:0] oCount;

    frame_timer #(.FPT_W(FPT_W), .CNT_W(CNT_W), .SYNC_STAGES(S)) dut (
        .iclk            (iclk),
        .irst            (irst),
        .ivsync          (ivsync),
        .ien             (ien),
        .iclr            (iclr),
        .imode           (imode),
        .iframes_per_tick(iframes_per_tick),
        .iterminal       (iterminal),
        .ovs_rise        (ovs_rise),
        .otick           (otick),
        .owrap           (owrap),
        .odone           (odone),
        .oCount          (oCount)
    );

    always #5 iclk = ~iclk;

    int errors = 0;
    int checks = 0;
    int rise_seen = 0, tick_seen = 0, wrap_seen = 0;

    always @(negedge iclk) begin
        if (ovs_rise) rise_seen++;
        if (otick)    tick_seen++;
        if (owrap)    wrap_seen++;
    end

    // Reference model: frames since last tick, tick count, one-shot finished.
    int m_frames, m_count;
    bit m_done;

    typedef struct {
        logic             en;
        logic             mode;
        logic [FPT_W-1:0] fpt;
        logic [CNT_W-1:0] term;
        logic             exp_tick;
        logic [CNT_W-1:0] exp_count;
        logic             exp_done;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t row(input logic t, input int c, input logic d);
        vec_t v;
        v.en = 1'b1; v.mode = MODE_ONESHOT; v.fpt = 10'd3; v.term = 8'd4;
        v.exp_tick = t; v.exp_count = 8'(c); v.exp_done = d;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic model_reset();
        m_frames = 0; m_count = 0; m_done = 0;
    endtask

    task automatic pulse(input string name, input logic et, input logic ew,
                         input logic [CNT_W-1:0] ec, input logic ed);
        bit seen = 0;
        @(negedge iclk) ivsync = 1'b1;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge iclk);
            if (ovs_rise) seen = 1;
        end
        check({name, "_rise"}, 32'(seen), 32'd1);
        if (seen) begin
            check({name, "_tick"},  32'(otick),  32'(et));
            check({name, "_wrap"},  32'(owrap),  32'(ew));
            check({name, "_count"}, 32'(oCount), 32'(ec));
            check({name, "_done"},  32'(odone),  32'(ed));
        end
        ivsync = 1'b0;
        repeat (2) @(negedge iclk);
    endtask

    task automatic pulse_model(input string name);
        bit t = 0, w = 0;
        int feff = (iframes_per_tick == 0) ? 1 : int'(iframes_per_tick);
        int meff = (iterminal == 0) ? 256 : int'(iterminal);
        if (ien && !m_done) begin
            m_frames++;
            if (m_frames >= feff) begin
                m_frames = 0;
                t = 1;
            end
        end
        if (t) begin
            if (imode == MODE_WRAP) begin
                if (m_count >= meff - 1) begin m_count = 0; w = 1; end
                else m_count++;
            end else if (m_count == meff - 1) begin
                m_done = 1;
            end else begin
                m_count = (m_count + 1) % 256;
            end
        end
        pulse(name, t, w, 8'(m_count), m_done);
    endtask

    task automatic fast(input int n);
        repeat (n) begin
            @(negedge iclk) ivsync = 1'b1;
            @(negedge iclk) ivsync = 1'b0;
        end
        repeat (6) @(negedge iclk);
    endtask

    task automatic do_clear();
        @(negedge iclk) iclr = 1'b1;
        @(negedge iclk) iclr = 1'b0;
        model_reset();
        check("clr_count", 32'(oCount), 32'd0);
        check("clr_done",  32'(odone),  32'd0);
    endtask

    task automatic config_in(input logic en, input logic mode, input int fpt, input int term);
        ien = en; imode = mode; iframes_per_tick = FPT_W'(fpt); iterminal = CNT_W'(term);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base_r, base_t, base_w;
        irst = 1'b1; ivsync = 1'b1; iclr = 1'b0;
        config_in(1'b0, MODE_WRAP, 1, 1);
        model_reset();

        // Test 3: vsync high across reset release, then exact edge latency.
        repeat (3) @(negedge iclk);
        check("rst_rise",  32'(ovs_rise), 32'd0);
        check("rst_tick",  32'(otick),    32'd0);
        check("rst_wrap",  32'(owrap),    32'd0);
        check("rst_done",  32'(odone),    32'd0);
        check("rst_count", 32'(oCount),   32'd0);
        irst = 1'b0;
        base_r = rise_seen;
        repeat (10) @(negedge iclk);
        check("high_at_release", 32'(rise_seen - base_r), 32'd0);
        ivsync = 1'b0;
        repeat (4) @(negedge iclk);
        ivsync = 1'b1;
        @(posedge iclk);
        repeat (S) @(posedge iclk);
        @(negedge iclk);
        check("latency_early", 32'(ovs_rise), 32'd0);
        @(negedge iclk);
        check("latency_exact", 32'(ovs_rise), 32'd1);
        ivsync = 1'b0;
        repeat (4) @(negedge iclk);

        // Test 1: F=60, M=255 wrap over long runs.
        config_in(1'b1, MODE_WRAP, 60, 255);
        do_clear();
        base_t = tick_seen; base_w = wrap_seen; base_r = rise_seen;
        fast(60);
        check("t1_one_tick",  32'(tick_seen - base_t), 32'd1);
        check("t1_count_1",   32'(oCount), 32'd1);
        fast(254 * 60);
        check("t1_wrap_once", 32'(wrap_seen - base_w), 32'd1);
        check("t1_ticks",     32'(tick_seen - base_t), 32'd255);
        check("t1_rises",     32'(rise_seen - base_r), 32'd15300);
        check("t1_count_0",   32'(oCount), 32'd0);

        // Test 2: F=3, M=4 one-shot, table-driven.
        tbl[0]  = row(0, 0, 0); tbl[1]  = row(0, 0, 0); tbl[2]  = row(1, 1, 0);
        tbl[3]  = row(0, 1, 0); tbl[4]  = row(0, 1, 0); tbl[5]  = row(1, 2, 0);
        tbl[6]  = row(0, 2, 0); tbl[7]  = row(0, 2, 0); tbl[8]  = row(1, 3, 0);
        tbl[9]  = row(0, 3, 0); tbl[10] = row(0, 3, 0); tbl[11] = row(1, 3, 1);
        for (int i = 12; i < 21; i++) tbl[i] = row(0, 3, 1);
        config_in(1'b1, MODE_ONESHOT, 3, 4);
        do_clear();
        for (int i = 0; i < 21; i++) begin
            config_in(tbl[i].en, tbl[i].mode, int'(tbl[i].fpt), int'(tbl[i].term));
            pulse($sformatf("t2_e%0d", i + 1), tbl[i].exp_tick, 1'b0,
                  tbl[i].exp_count, tbl[i].exp_done);
        end
        imode = MODE_WRAP;
        pulse("t2_wrap_in_done", 1'b0, 1'b0, 8'd3, 1'b1);
        do_clear();

        // Test 4: enable low freezes counters, edges still reported.
        config_in(1'b1, MODE_WRAP, 2, 10);
        do_clear();
        for (int i = 0; i < 3; i++) pulse_model("t4_pre");
        ien = 1'b0;
        for (int i = 0; i < 5; i++) pulse_model("t4_hold");
        ien = 1'b1;
        for (int i = 0; i < 4; i++) pulse_model("t4_resume");

        // Test 5: clear coincident with the counting edge at fcnt=F-1.
        config_in(1'b1, MODE_WRAP, 3, 10);
        do_clear();
        for (int i = 0; i < 5; i++) pulse_model("t5_pre");
        @(negedge iclk) ivsync = 1'b1;
        repeat (S + 1) @(posedge iclk);
        @(negedge iclk) iclr = 1'b1;
        @(negedge iclk);
        iclr = 1'b0;
        check("t5_rise",  32'(ovs_rise), 32'd1);
        check("t5_tick",  32'(otick),    32'd0);
        check("t5_count", 32'(oCount),   32'd0);
        ivsync = 1'b0;
        repeat (3) @(negedge iclk);
        model_reset();
        for (int i = 0; i < 3; i++) pulse_model("t5_post");

        // Test 6: F=0, M=0 ticks every vsync, wraps after 256; reset mid-count.
        config_in(1'b1, MODE_WRAP, 0, 0);
        do_clear();
        for (int i = 0; i < 256; i++) pulse_model($sformatf("t6_v%0d", i + 1));
        for (int i = 0; i < 5; i++) pulse_model("t6_more");
        @(negedge iclk) irst = 1'b1;
        @(negedge iclk);
        check("t6_rst_count", 32'(oCount),   32'd0);
        check("t6_rst_flags", 32'({ovs_rise, otick, owrap, odone}), 32'd0);
        irst = 1'b0;
        model_reset();
        repeat (6) @(negedge iclk);

        // Randomized run against the reference model.
        for (int i = 0; i < 120; i++) begin
            if (i % 6 == 0)
                config_in(($urandom % 5) != 0, ($urandom % 3) == 0,
                          int'($urandom % 4), int'($urandom % 5));
            if ($urandom % 12 == 0) do_clear();
            pulse_model($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
